pipe_adder: RTL and testbench

Parametrised, segmented, pipelined two's-complement adder/subtractor with valid/ready handshakes at both ports. A WIDTH-bit operation is split into NSEG = WIDTH/SEG_W segments. Each pipeline stage resolves one segment and passes its carry forward in a register, so clock rate is set by a SEG_W-bit ripple rather than a WIDTH-bit one. It sits between the operand fetch and the accumulation stage of the matrix-multiplier datapath, and replaces chains of single-bit adder cells.

---
 rtl/adder_pkg.sv | 18 +
 rtl/seg_adder.sv | 27 ++
 rtl/pipe_adder.sv | 121 ++++++++++++
 tb/tb_pipe_adder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and parameter helpers for the segmented pipelined adder
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_t;

  function automatic int nseg(input int width, input int seg_w);
    if (seg_w < 1 || width < seg_w) return 1;
    return width / seg_w;
  endfunction

  function automatic bit params_ok(input int width, input int seg_w);
    return (seg_w >= 1) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

endpackage

// File: rtl/seg_adder.sv
// rtl/seg_adder.sv - combinational SEG_W-bit ripple adder segment
module seg_adder #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic c;

  always_comb begin
    sum  = '0;
    cmsb = 1'b0;
    c    = cin;
    for (int i = 0; i < SEG_W; i++) begin
      if (i == SEG_W - 1) cmsb = c;
      sum[i] = a[i] ^ b[i] ^ c;
      c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/pipe_adder.sv
// rtl/pipe_adder.sv - segmented pipelined add/sub with a global-stall valid/ready pipeline
module pipe_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  op_t              in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  if (!params_ok(WIDTH, SEG_W)) begin : g_param_check
    $error("pipe_adder: WIDTH must be a multiple of SEG_W and SEG_W >= 1");
  end

  logic                       advance;
  logic [NSEG-1:0]            valid_q;
  logic [NSEG-1:0]            carry_q;
  logic [NSEG-1:0][WIDTH-1:0] sum_q;
  logic [NSEG-1:0][WIDTH-1:0] a_q;
  logic [NSEG-1:0][WIDTH-1:0] b_q;
  logic                       ovf_q;

  // Every stage moves together; a full-but-draining pipe still accepts.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_sum;
    logic [WIDTH-1:0] nxt_sum;
    logic             src_v;
    logic             src_c;
    logic [SEG_W-1:0] seg_s;
    logic             seg_co;
    logic             seg_cm;

    if (k == 0) begin : g_first
      // Subtraction is A + ~B + 1, with the +1 entering as stage-0 carry-in.
      assign src_a   = in_a;
      assign src_b   = in_b ^ {WIDTH{in_op == OP_SUB}};
      assign src_c   = (in_op == OP_SUB);
      assign src_v   = in_valid;
      assign src_sum = '0;
    end else begin : g_next
      assign src_a   = a_q[k-1];
      assign src_b   = b_q[k-1];
      assign src_c   = carry_q[k-1];
      assign src_v   = valid_q[k-1];
      assign src_sum = sum_q[k-1];
    end

    seg_adder #(
      .SEG_W(SEG_W)
    ) u_seg (
      .a   (src_a[k*SEG_W +: SEG_W]),
      .b   (src_b[k*SEG_W +: SEG_W]),
      .cin (src_c),
      .sum (seg_s),
      .cout(seg_co),
      .cmsb(seg_cm)
    );

    always_comb begin
      nxt_sum                    = src_sum;
      nxt_sum[k*SEG_W +: SEG_W]  = seg_s;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q[k] <= 1'b0;
        carry_q[k] <= 1'b0;
        sum_q[k]   <= '0;
        a_q[k]     <= '0;
        b_q[k]     <= '0;
      end else if (advance) begin
        valid_q[k] <= src_v;
        carry_q[k] <= seg_co;
        sum_q[k]   <= nxt_sum;
        a_q[k]     <= src_a;
        b_q[k]     <= src_b;
      end
    end

    if (k == NSEG - 1) begin : g_last
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= seg_cm ^ seg_co;
        end
      end
    end else begin : g_mid
      logic unused_cm;
      assign unused_cm = seg_cm;
    end
  end

  // The final stage's operand copies are fully consumed; nothing downstream reads them.
  logic unused_last_ops;
  assign unused_last_ops = ^{a_q[NSEG-1], b_q[NSEG-1]};

  assign out_valid = valid_q[NSEG-1];
  assign out_sum   = sum_q[NSEG-1];
  assign out_cout  = carry_q[NSEG-1];
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// tb/tb_pipe_adder.sv - self-checking bench for pipe_adder with arithmetic reference model
module tb_pipe_adder;
  import adder_pkg::*;

  localparam int WIDTH = 16;
  localparam int SEG_W = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  op_t         in_op = OP_ADD;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  int   checks = 0;
  int   failures = 0;
  res_t expq[$];
  int   cyc = 0;
  int   emits = 0;
  int   first_emit = -1;
  int   last_emit = -1;
  logic prev_stall = 1'b0;
  res_t prev_out = '0;
  bit   tx_done = 1'b0;

  always #5 clk = ~clk;

  pipe_adder #(
    .WIDTH(WIDTH),
    .SEG_W(SEG_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .out_ovf  (out_ovf)
  );

  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input op_t op);
    res_t        r;
    int unsigned ua = a;
    int unsigned ub = b;
    int unsigned full;
    int          sa = $signed(a);
    int          sb = $signed(b);
    int          sr;
    if (op == OP_ADD) begin
      full   = ua + ub;
      r.sum  = full[15:0];
      r.cout = full[16];
      sr     = sa + sb;
    end else begin
      full   = ua - ub;
      r.sum  = full[15:0];
      r.cout = (ua >= ub);
      sr     = sa - sb;
    end
    r.ovf = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    res_t e;
    cyc++;
    if (!rst_n) begin
      expq.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold_while_stalled", {out_valid, out_sum, out_cout, out_ovf}, {1'b1, prev_out});
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%0h required=none", out_sum);
        end else begin
          e = expq.pop_front();
          chk("result", {out_sum, out_cout, out_ovf}, e);
        end
        if (emits == 0) first_emit = cyc;
        last_emit = cyc;
        emits++;
      end
      if (in_valid && in_ready) expq.push_back(model(in_a, in_b, in_op));
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_sum, out_cout, out_ovf};
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input op_t op);
    bit ok = 1'b0;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output res_t r);
    bit ok = 1'b0;
    r = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (out_valid) begin
        r  = {out_sum, out_cout, out_ovf};
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_out_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input op_t op, input res_t exp);
    res_t r;
    send(a, b, op);
    wait_out(r);
    chk(name, r, exp);
  endtask

  task automatic drain(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(posedge clk);
      #1;
      if (expq.size() == 0 && !out_valid) break;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    int   seen;
    logic ov1, ov2, ov3;

    // Reset then idle
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_outputs", {out_sum, out_cout, out_ovf}, 18'h0);
    chk("reset_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("idle_no_valid", seen, 0);
    chk("idle_in_ready", in_ready, 1'b1);

    // Single ADD with latency check
    out_ready = 1'b1;
    send(16'h1234, 16'h0FFF, OP_ADD);
    @(posedge clk); #1; ov1 = out_valid;
    @(posedge clk); #1; ov2 = out_valid;
    @(posedge clk); #1; ov3 = out_valid;
    chk("latency_profile", {ov1, ov2, ov3}, 3'b001);
    chk("add_1234_0fff", {out_sum, out_cout, out_ovf}, {16'h2233, 1'b0, 1'b0});
    drain(20);

    // SUB, overflow, wrap-around
    directed("sub_5_7", 16'h0005, 16'h0007, OP_SUB, {16'hFFFE, 1'b0, 1'b0});
    directed("add_7fff_1", 16'h7FFF, 16'h0001, OP_ADD, {16'h8000, 1'b0, 1'b1});
    directed("add_ffff_1", 16'hFFFF, 16'h0001, OP_ADD, {16'h0000, 1'b1, 1'b0});
    directed("sub_8000_1", 16'h8000, 16'h0001, OP_SUB, {16'h7FFF, 1'b1, 1'b1});
    directed("sub_equal", 16'hA5A5, 16'hA5A5, OP_SUB, {16'h0000, 1'b1, 1'b0});
    drain(20);

    // Back-to-back stream
    emits = 0;
    for (int i = 0; i < 32; i++)
      send(16'($urandom), 16'($urandom), op_t'($urandom_range(0, 1)));
    drain(50);
    chk("stream_count", emits, 32);
    chk("stream_span", last_emit - first_emit, 31);

    // Random valid and backpressure
    emits   = 0;
    tx_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
          end
          send(16'($urandom), 16'($urandom), op_t'($urandom_range(0, 1)));
        end
        tx_done = 1'b1;
      end
      begin
        while (!tx_done) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain(50);
    chk("bp_count", emits, 1000);
    chk("bp_queue_empty", expq.size(), 0);

    // Reset with beats in flight
    send(16'h1111, 16'h2222, OP_ADD);
    send(16'h3333, 16'h4444, OP_SUB);
    send(16'h5555, 16'h6666, OP_ADD);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midreset_out_valid", out_valid, 1'b0);
    emits = 0;
    directed("after_reset_1_1", 16'h0001, 16'h0001, OP_ADD, {16'h0002, 1'b0, 1'b0});
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("midreset_single_result", emits, 1);
    chk("midreset_queue_empty", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
